rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one registered output channel between 4 requesters.
- Each requester has a valid/ready handshake; the arbiter picks one winner per transfer.
- The winner index drives the select of an internal 4-to-1 data mux.
- Sits between independent producers and a single downstream consumer. Uses the basic 4:1 mux block as its datapath.

Parameters:
- DATA_W, 8, width of each requester's data word and of out_data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  4  per-requester valid; bit k belongs to requester k.
- in_data  input  4*DATA_W  concatenated requester data; requester k occupies bits [k*DATA_W +: DATA_W].
- in_lock  input  4  per-requester lock request; only used when RR_ARB_LOCK_EN is defined.
- in_ready  output  4  per-requester ready, one-hot or zero, combinational.
- out_valid  output  1  registered output valid.
- out_data  output  DATA_W  registered output data.
- out_sel  output  2  registered index of the requester whose data is in out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, out_data=0, out_sel=0, ptr=0, last_win=0. Reset has priority over every other event, including mid-transfer with out_valid=1; the held word is dropped.
- While rst_n=0, in_ready=4'b0000.
- load = !out_valid || out_ready. This is the "slot free" condition and gives full throughput with skid-free pass-through.
- Winner search: scan requesters ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first with in_valid=1 wins.
- If load=1 and any in_valid=1, the load is accepted:
  - in_ready[winner]=1 in the same cycle; all other in_ready bits are 0.
  - On the clock edge: out_data <= in_data[winner], out_sel <= winner, out_valid <= 1, last_win <= winner, ptr <= (winner+1) mod 4.
- If load=1 and in_valid=0: out_valid <= 0 at the edge. out_data and out_sel hold their last values. ptr is unchanged.
- If load=0 (out_valid=1, out_ready=0): all outputs and ptr hold, and in_ready=0.
- Latency: data presented in cycle N with in_ready=1 appears on out_data in cycle N+1. Throughput is 1 word per cycle while out_ready=1.
- Fairness: any continuously valid requester is granted within 4 accepted transfers.
- Two-state control, derived from out_valid:
  - EMPTY (out_valid=0) -> FULL on an accepted load.
  - FULL -> FULL on a handshake plus a new load.
  - FULL -> EMPTY on a handshake with no valid requester.
  - FULL -> FULL (hold) when out_ready=0.
- ptr wraps 3->0. out_sel is 2 bits, no overflow.
- in_data of non-winners is ignored. in_valid may drop without a handshake; no data is lost, because only accepted words are captured.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined: if in_valid[last_win]=1, in_lock[last_win]=1 and out_valid=1 (that requester holds the output), then last_win wins the next load regardless of ptr, and ptr is not advanced. Releasing in_lock returns to round-robin from the stored ptr.
- Undefined: the in_lock port exists but is ignored; pure round-robin.

Decomposition:
- Package rr_arb_pkg holds: NUM_REQ=4, SEL_W=2, state encoding EMPTY=1'b0 / FULL=1'b1.
- Sub-module mux4_dw: parametric DATA_W 4:1 mux, select = winner, combinational. It feeds the out_data register.
- Winner search, ptr and output registers stay in rr_mux_arbiter.

Test Plan:
- Reset: rst_n=0 for 3 cycles with in_valid=4'b1111 -> in_ready=4'b0000, out_valid=0, out_data=0, out_sel=0. Assert rst_n=0 while out_valid=1 -> next edge out_valid=0, and the next grant goes to requester 0.
- Single requester: in_valid=4'b0100, requester-2 data=8'hA5, out_ready=1 -> in_ready=4'b0100 in the same cycle. Next cycle out_valid=1, out_data=8'hA5, out_sel=2.
- All valid, out_ready=1, data k=8'h10+k -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_data 10,11,12,13,10,11.
- Backpressure: out_valid=1, out_sel=1, out_ready=0 for 5 cycles with in_valid=4'b1111 -> in_ready=0000 and out_data/out_sel stable. Raise out_ready -> the next grant is requester 2.
- Pointer skip: after a grant to requester 2, in_valid=4'b1001 -> grants 3 then 0. Then in_valid=0 with out_ready=1 -> out_valid=0 next cycle.
- Lock (RR_ARB_LOCK_EN defined): in_valid=4'b1111, in_lock=4'b0010 after a grant to requester 1 -> out_sel stays 1 for every transfer. Clear in_lock -> sequence 2,3,0. Same stimulus with the macro undefined -> 2,3,0,1 immediately.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
package rr_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/mux4_dw.sv
// Parametric-width 4:1 combinational data mux feeding the output register.
module mux4_dw #(
    parameter int DATA_W = 8
) (
    input  logic [3:0][DATA_W-1:0] din,
    input  logic [1:0]             sel,
    output logic [DATA_W-1:0]      dout
);
    assign dout = din[sel];
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered output channel between 4 requesters.
// Optional macro RR_ARB_LOCK_EN lets the current owner keep the channel while it holds in_lock.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        in_valid,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic [NUM_REQ-1:0]        in_lock,
    output logic [NUM_REQ-1:0]        in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);
    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] last_win;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] idx;
    logic             found;
    logic             lock_hit;
    logic             load;
    logic             accept;
    logic [DATA_W-1:0] mux_out;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        winner   = ptr;
        idx      = ptr;
        found    = 1'b0;
        lock_hit = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (in_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
`ifdef RR_ARB_LOCK_EN
        if (state == FULL && in_valid[last_win] && in_lock[last_win]) begin
            winner   = last_win;
            found    = 1'b1;
            lock_hit = 1'b1;
        end
`endif
    end

`ifndef RR_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^in_lock;
`endif

    assign load     = (state == EMPTY) || out_ready;
    assign accept   = load && found;
    assign in_ready = (rst_n && accept) ? (NUM_REQ'(1) << winner) : '0;

    mux4_dw #(.DATA_W(DATA_W)) u_mux (
        .din  (in_data),
        .sel  (winner),
        .dout (mux_out)
    );

    // Output slot control; a reset drops any word still held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
            last_win <= '0;
        end else if (load) begin
            if (found) begin
                state    <= FULL;
                out_data <= mux_out;
                out_sel  <= winner;
                last_win <= winner;
                if (!lock_hit)
                    ptr <= winner + SEL_W'(1);
            end else begin
                state <= EMPTY;
            end
        end
    end

    assign out_valid = (state == FULL);
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter with hand-computed expectations.
module tb_rr_mux_arbiter;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]        in_lock;
    logic [3:0]        in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_sel;
    logic              out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    rr_mux_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_lock   (in_lock),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One accepted transfer: check the grant, clock it, check the registered word.
    task automatic xfer(input string tag, input int sel);
        logic [3:0] onehot;
        onehot = 4'b0001 << sel;
        #1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'(onehot));
        tick();
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_sel"}, 32'(out_sel), 32'(sel));
        chk({tag, "_dat"}, 32'(out_data), 32'h10 + 32'(sel));
    endtask

    int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
`ifdef RR_ARB_LOCK_EN
    int exp_lk[6] = '{1, 1, 1, 2, 3, 0};
`else
    int exp_lk[6] = '{2, 3, 0, 1, 2, 3};
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        in_lock   = 4'b0000;
        out_ready = 1'b1;

        // Reset held for 3 cycles with all requesters valid
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rdy", 32'(in_ready), 32'h0);
            chk("rst_vld", 32'(out_valid), 32'd0);
            chk("rst_dat", 32'(out_data), 32'h0);
            chk("rst_sel", 32'(out_sel), 32'h0);
        end

        // Single requester 2
        rst_n    = 1'b1;
        in_valid = 4'b0100;
        in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
        #1;
        chk("single_rdy", 32'(in_ready), 32'h4);
        tick();
        chk("single_vld", 32'(out_valid), 32'd1);
        chk("single_dat", 32'(out_data), 32'hA5);
        chk("single_sel", 32'(out_sel), 32'd2);

        // Reset while holding a word: word dropped, pointer back to 0
        rst_n    = 1'b0;
        in_valid = 4'b0000;
        tick();
        chk("midrst_vld", 32'(out_valid), 32'd0);
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};

        // Full rotation with all valid
        for (int i = 0; i < 6; i++)
            xfer($sformatf("rr%0d", i), exp_rr[i]);

        // Backpressure holding sel=1
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy", 32'(in_ready), 32'h0);
            tick();
            chk("bp_vld", 32'(out_valid), 32'd1);
            chk("bp_sel", 32'(out_sel), 32'd1);
            chk("bp_dat", 32'(out_data), 32'h11);
        end
        out_ready = 1'b1;
        xfer("bp_rel", 2);

        // Pointer skip over idle requesters
        in_valid = 4'b1001;
        xfer("skip3", 3);
        xfer("skip0", 0);
        in_valid = 4'b0000;
        #1;
        chk("idle_rdy", 32'(in_ready), 32'h0);
        tick();
        chk("idle_vld", 32'(out_valid), 32'd0);
        chk("idle_sel", 32'(out_sel), 32'd0);
        chk("idle_dat", 32'(out_data), 32'h10);

        // Lock by requester 1 after it wins, then release
        in_valid = 4'b1111;
        xfer("pre_lock", 1);
        in_lock = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) in_lock = 4'b0000;
            xfer($sformatf("lock%0d", i), exp_lk[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
